// File: rtl/if_id_queue.sv
// IF/ID instruction queue: DEPTH-entry FIFO between fetch and decode with registered decode outputs.
// Optional macro IF_ID_BYPASS_EN: empty-queue fetch goes straight to the decode registers (1-cycle latency).
module if_id_queue #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32,
   parameter int DEPTH  = 4,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        stall,
   input  logic              flush,
   input  logic              if_valid,
   input  logic [ADDR_W-1:0] if_pc,
   input  logic [INST_W-1:0] if_inst,
   output logic              if_ready,
   output logic              stallreq_if,
   output logic [ADDR_W-1:0] id_pc,
   output logic [INST_W-1:0] id_inst,
   output logic              id_valid,
   output logic [CNT_W-1:0]  count,
   output logic              empty,
   output logic              full
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [ADDR_W-1:0] mem_pc   [DEPTH];
   logic [INST_W-1:0] mem_inst [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              push;
   logic              pop;
   logic              bypass;
   logic              decode_run;

   // Status derives only from the registered occupancy count.
   assign full        = (count == CNT_W'(DEPTH));
   assign empty       = (count == {CNT_W{1'b0}});
   assign if_ready    = ~full;
   assign stallreq_if = full;
   assign decode_run  = ~stall[2];

   // Transfer qualifiers; bypass and pop are mutually exclusive (empty vs not empty).
   always_comb begin
      bypass = 1'b0;
`ifdef IF_ID_BYPASS_EN
      if (empty && if_valid && decode_run && !flush) begin
         bypass = 1'b1;
      end else begin
         bypass = 1'b0;
      end
`else
      bypass = 1'b0;
`endif
      push = if_valid & ~full & ~flush & ~bypass;
      pop  = decode_run & ~empty & ~flush;
   end

   // Queue storage, deliberately not reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc[wr_ptr]   <= if_pc;
         mem_inst[wr_ptr] <= if_inst;
      end
   end

   // Pointers and occupancy; power-of-two depth makes the pointer wrap natural.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= {PTR_W{1'b0}};
         rd_ptr <= {PTR_W{1'b0}};
         count  <= {CNT_W{1'b0}};
      end else if (flush) begin
         wr_ptr <= {PTR_W{1'b0}};
         rd_ptr <= {PTR_W{1'b0}};
         count  <= {CNT_W{1'b0}};
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Decode-side registers: flush clears, a stalled decode holds, a running decode takes head, bypass or bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_pc    <= {ADDR_W{1'b0}};
         id_inst  <= {INST_W{1'b0}};
         id_valid <= 1'b0;
      end else if (flush) begin
         id_pc    <= {ADDR_W{1'b0}};
         id_inst  <= {INST_W{1'b0}};
         id_valid <= 1'b0;
      end else if (decode_run) begin
         if (pop) begin
            id_pc    <= mem_pc[rd_ptr];
            id_inst  <= mem_inst[rd_ptr];
            id_valid <= 1'b1;
         end else if (bypass) begin
            id_pc    <= if_pc;
            id_inst  <= if_inst;
            id_valid <= 1'b1;
         end else begin
            id_pc    <= {ADDR_W{1'b0}};
            id_inst  <= {INST_W{1'b0}};
            id_valid <= 1'b0;
         end
      end else begin
         id_pc    <= id_pc;
         id_inst  <= id_inst;
         id_valid <= id_valid;
      end
   end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus randomized traffic against a queue-based model.
module tb_if_id_queue;

   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [5:0]        stall = 6'd0;
   logic              flush = 1'b0;
   logic              if_valid = 1'b0;
   logic [31:0]       if_pc = 32'd0;
   logic [31:0]       if_inst = 32'd0;
   logic              if_ready;
   logic              stallreq_if;
   logic [31:0]       id_pc;
   logic [31:0]       id_inst;
   logic              id_valid;
   logic [CNT_W-1:0]  count;
   logic              empty;
   logic              full;

   int checks = 0;
   int failures = 0;

   // Reference model: plain queue of fetched entries plus the decode registers.
   logic [31:0] q_pc[$];
   logic [31:0] q_inst[$];
   logic [31:0] m_pc;
   logic [31:0] m_inst;
   logic        m_valid;
   logic        last_acc;

   if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
      .if_ready(if_ready), .stallreq_if(stallreq_if),
      .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid),
      .count(count), .empty(empty), .full(full)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return pc ^ 32'hA5C3_0000;
   endfunction

   task automatic model_clear();
      q_pc.delete();
      q_inst.delete();
      m_pc = 32'd0;
      m_inst = 32'd0;
      m_valid = 1'b0;
      last_acc = 1'b0;
   endtask

   // One clock: drive inputs (unused stall bits random), clock edge, advance model, settle.
   task automatic step(input logic s2, input logic fl, input logic v,
                       input logic [31:0] pc, input logic [31:0] in);
      int sz;
      logic byp;
      logic [5:0] r;
      r = 6'($urandom) & 6'b111011;
      stall = r | {3'b000, s2, 2'b00};
      flush = fl;
      if_valid = v;
      if_pc = pc;
      if_inst = in;
      @(posedge clk);
      sz = q_pc.size();
      byp = 1'b0;
      last_acc = 1'b0;
      if (fl) begin
         q_pc.delete();
         q_inst.delete();
         m_pc = 32'd0;
         m_inst = 32'd0;
         m_valid = 1'b0;
      end else begin
`ifdef IF_ID_BYPASS_EN
         byp = (sz == 0) && v && !s2;
`endif
         if (!s2) begin
            if (sz != 0) begin
               m_pc = q_pc.pop_front();
               m_inst = q_inst.pop_front();
               m_valid = 1'b1;
            end else if (byp) begin
               m_pc = pc;
               m_inst = in;
               m_valid = 1'b1;
            end else begin
               m_pc = 32'd0;
               m_inst = 32'd0;
               m_valid = 1'b0;
            end
         end
         if (v && sz < DEPTH && !byp) begin
            q_pc.push_back(pc);
            q_inst.push_back(in);
            last_acc = 1'b1;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #3;
      rst = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      checks++;
      if (count !== 3'd0 || empty !== 1'b1 || id_valid !== 1'b0 || id_pc !== 32'd0 || id_inst !== 32'd0) begin
         failures++;
         $display("FAIL reset_initial count=%0d empty=%b id_valid=%b id_pc=%h id_inst=%h required 0/1/0/0/0",
                  count, empty, id_valid, id_pc, id_inst);
      end
      rst = 1'b0;
      model_clear();
      step(1'b1, 1'b0, 1'b1, 32'h50, inst_of(32'h50));
      step(1'b1, 1'b0, 1'b1, 32'h54, inst_of(32'h54));
      step(1'b1, 1'b0, 1'b1, 32'h58, inst_of(32'h58));
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b1, 1'b0, 1'b1, 32'h5C, inst_of(32'h5C));
      checks++;
      if (count !== 3'd3 || id_valid !== 1'b1 || id_pc !== 32'h50) begin
         failures++;
         $display("FAIL reset_prefill count=%0d id_valid=%b id_pc=%h required 3/1/00000050", count, id_valid, id_pc);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || id_valid !== 1'b0 ||
          id_pc !== 32'd0 || id_inst !== 32'd0) begin
         failures++;
         $display("FAIL reset_async count=%0d empty=%b full=%b id_valid=%b id_pc=%h id_inst=%h required 0/1/0/0/0/0",
                  count, empty, full, id_valid, id_pc, id_inst);
      end
      #1;
      rst = 1'b0;
      model_clear();
   endtask

   task automatic test_fill_drain();
      logic [31:0] next_pc;
      int got;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 1'b0, 1'b1, 32'h100 + 32'(4 * k), inst_of(32'h100 + 32'(4 * k)));
      end
      checks++;
      if (full !== 1'b1 || stallreq_if !== 1'b1 || if_ready !== 1'b0 || count !== 3'd4 || id_valid !== 1'b0) begin
         failures++;
         $display("FAIL fill_full full=%b stallreq=%b if_ready=%b count=%0d id_valid=%b required 1/1/0/4/0",
                  full, stallreq_if, if_ready, count, id_valid);
      end
      step(1'b1, 1'b0, 1'b1, 32'h110, inst_of(32'h110));
      checks++;
      if (count !== 3'd4 || full !== 1'b1) begin
         failures++;
         $display("FAIL fill_overflow count=%0d full=%b required 4/1", count, full);
      end
      next_pc = 32'h110;
      got = 0;
      for (int cyc = 0; cyc < 30 && got < 8; cyc++) begin
         step(1'b0, 1'b0, next_pc <= 32'h11C, next_pc, inst_of(next_pc));
         if (last_acc) next_pc = next_pc + 32'd4;
         checks++;
         if (id_valid !== m_valid) begin
            failures++;
            $display("FAIL drain_valid cycle=%0d id_valid=%b required %b", cyc, id_valid, m_valid);
         end
         if (id_valid === 1'b1) begin
            checks++;
            if (id_pc !== 32'h100 + 32'(4 * got) || id_inst !== inst_of(32'h100 + 32'(4 * got))) begin
               failures++;
               $display("FAIL drain_order idx=%0d id_pc=%h id_inst=%h required %h/%h", got, id_pc, id_inst,
                        32'h100 + 32'(4 * got), inst_of(32'h100 + 32'(4 * got)));
            end
            got++;
         end
      end
      checks++;
      if (got != 8) begin
         failures++;
         $display("FAIL drain_count got=%0d required 8", got);
      end
   endtask

   task automatic test_bubble();
      do_reset();
      step(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFF);
      checks++;
      if (id_valid !== 1'b0 || id_inst !== 32'd0 || id_pc !== 32'd0) begin
         failures++;
         $display("FAIL bubble_idle id_valid=%b id_inst=%h id_pc=%h required 0/0/0", id_valid, id_inst, id_pc);
      end
      step(1'b0, 1'b0, 1'b1, 32'h200, inst_of(32'h200));
`ifdef IF_ID_BYPASS_EN
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'h200 || count !== 3'd0) begin
         failures++;
         $display("FAIL bubble_bypass id_valid=%b id_pc=%h count=%0d required 1/00000200/0", id_valid, id_pc, count);
      end
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      checks++;
      if (id_valid !== 1'b0 || id_inst !== 32'd0) begin
         failures++;
         $display("FAIL bubble_after id_valid=%b id_inst=%h required 0/0", id_valid, id_inst);
      end
`else
      checks++;
      if (id_valid !== 1'b0 || count !== 3'd1) begin
         failures++;
         $display("FAIL bubble_latency1 id_valid=%b count=%0d required 0/1", id_valid, count);
      end
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_inst !== inst_of(32'h200) || count !== 3'd0) begin
         failures++;
         $display("FAIL bubble_latency2 id_valid=%b id_pc=%h count=%0d required 1/00000200/0", id_valid, id_pc, count);
      end
`endif
   endtask

   task automatic test_flush();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b0, 1'b1, 32'h300 + 32'(4 * k), inst_of(32'h300 + 32'(4 * k)));
      end
      step(1'b0, 1'b1, 1'b1, 32'h3FC, inst_of(32'h3FC));
      checks++;
      if (count !== 3'd0 || empty !== 1'b1 || id_valid !== 1'b0 || id_inst !== 32'd0 || id_pc !== 32'd0) begin
         failures++;
         $display("FAIL flush_clear count=%0d empty=%b id_valid=%b id_inst=%h id_pc=%h required 0/1/0/0/0",
                  count, empty, id_valid, id_inst, id_pc);
      end
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
         checks++;
         if (id_valid !== 1'b0 || id_pc === 32'h3FC) begin
            failures++;
            $display("FAIL flush_leak cycle=%0d id_valid=%b id_pc=%h required 0 and never 000003fc", k, id_valid, id_pc);
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      step(1'b1, 1'b0, 1'b1, 32'h400, inst_of(32'h400));
      step(1'b1, 1'b0, 1'b1, 32'h404, inst_of(32'h404));
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 1'b0, 1'b1, 32'h408 + 32'(4 * k), inst_of(32'h408 + 32'(4 * k)));
         checks++;
         if (count !== 3'd2 || id_valid !== 1'b1 || id_pc !== 32'h400 + 32'(4 * k)) begin
            failures++;
            $display("FAIL b2b cycle=%0d count=%0d id_valid=%b id_pc=%h required 2/1/%h",
                     k, count, id_valid, id_pc, 32'h400 + 32'(4 * k));
         end
      end
   endtask

   task automatic test_random();
      logic s2, fl, v;
      logic [31:0] pc;
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         s2 = ($urandom_range(0, 99) < 40);
         fl = ($urandom_range(0, 99) < 4);
         v  = ($urandom_range(0, 99) < 65);
         pc = $urandom;
         step(s2, fl, v, pc, $urandom);
         checks++;
         if (count !== CNT_W'(q_pc.size()) || empty !== (q_pc.size() == 0) ||
             full !== (q_pc.size() == DEPTH) || if_ready !== (q_pc.size() != DEPTH) ||
             stallreq_if !== (q_pc.size() == DEPTH) || id_valid !== m_valid ||
             id_pc !== m_pc || id_inst !== m_inst) begin
            failures++;
            $display("FAIL random cycle=%0d count=%0d/%0d full=%b empty=%b id_valid=%b/%b id_pc=%h/%h id_inst=%h/%h (actual/required)",
                     cyc, count, q_pc.size(), full, empty, id_valid, m_valid, id_pc, m_pc, id_inst, m_inst);
         end
      end
   endtask

   initial begin
      #12;
      test_reset();
      test_fill_drain();
      test_bubble();
      test_flush();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
Parametrised successor of the IF/ID pipeline register. It places a DEPTH-entry instruction queue between the fetch and decode stages, so fetch keeps running while decode is stalled. It keeps the 6-bit stall-vector contract and adds a synchronous flush and a registered full/empty status. It drives a registered decode-side output pair (id_pc, id_inst) plus id_valid.

Parameters:
ADDR_W, 32, width of instruction address (pc)
INST_W, 32, width of instruction word
DEPTH, 4, queue entries; power of two, 2..16
CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
stall  in  6  pipeline stall vector; only stall[2] (decode) is used; 1 = Stop
flush  in  1  synchronous flush (exception/branch redirect)
if_valid  in  1  fetch presents a valid instruction this cycle
if_pc  in  ADDR_W  address of fetched instruction
if_inst  in  INST_W  fetched instruction
if_ready  out  1  queue can accept (= !full), combinational from registered count
stallreq_if  out  1  = full; fetch-stall request to the controller
id_pc  out  ADDR_W  decode-stage address
id_inst  out  INST_W  decode-stage instruction
id_valid  out  1  id_pc/id_inst hold a real instruction, not a bubble
count  out  CNT_W  current queue occupancy, 0..DEPTH
empty  out  1  count == 0
full  out  1  count == DEPTH

Behaviour:
- Reset, asynchronous: wr_ptr, rd_ptr, count = 0; id_pc, id_inst = 0; id_valid = 0. Storage array is not reset. Reset mid-operation discards all entries immediately.
- push = if_valid & !full & !flush. Writes {if_pc, if_inst} at wr_ptr; wr_ptr increments modulo DEPTH.
- full blocks push even if a pop occurs in the same cycle. No write-through when full. Fetch must hold the instruction while if_ready = 0.
- pop = (stall[2] == 0) & !empty & !flush. Head entry loads into id_pc/id_inst, id_valid <= 1; rd_ptr increments modulo DEPTH.
- stall[2] == 0 and empty (no flush): id_pc, id_inst <= 0 and id_valid <= 0. This inserts a bubble (nop).
- stall[2] == 1: id_pc, id_inst and id_valid hold; no pop.
- count next = count + push - pop. Simultaneous push and pop leaves count unchanged.
- Pointers wrap from DEPTH-1 to 0 with no gap.
- Push into an empty queue is visible at the output no earlier than the next cycle (2-cycle if->id latency), unless the bypass option is enabled.
- flush, highest priority after reset: pointers and count <= 0; id_pc, id_inst <= 0; id_valid <= 0. The same-cycle if_valid is dropped. Flush overrides stall[2].
- Outputs are registers; if_ready, stallreq_if, empty and full derive only from count (no input-to-output combinational path).

Optional Feature:
IF_ID_BYPASS_EN
- Defined: when empty, if_valid = 1, stall[2] = 0 and no flush, {if_pc, if_inst} loads directly into id_pc/id_inst with id_valid <= 1. Nothing is written to the queue and count stays 0, giving 1-cycle latency like the single-register stage.
- Undefined: no bypass; the rules above apply, and an empty queue with decode running emits a bubble.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with 3 entries queued -> count = 0, empty = 1, id_pc = 0, id_inst = 0, id_valid = 0 before the next edge.
- Decode stall fill: DEPTH = 4, stall[2] = 1, push pc 0x100/0x104/0x108/0x10C -> full = 1, stallreq_if = 1, if_ready = 0. A 5th push (0x110) is ignored and count stays 4.
- Drain order and wrap: from the full state, release stall[2] while pushing 0x110..0x11C over 8 cycles -> id_pc sequence is 0x100, 0x104, ... 0x11C in order with no loss or duplication across pointer wrap.
- Bubble insertion: empty queue, stall[2] = 0, if_valid = 0 -> id_inst = 0, id_valid = 0. One push of 0x200 -> id_pc = 0x200 two cycles later, or one cycle later with IF_ID_BYPASS_EN defined.
- Flush priority: count = 3, flush = 1 together with if_valid = 1 and stall[2] = 0 -> next cycle count = 0, id_valid = 0, id_inst = 0, and the flushed-cycle pc never appears.
- Simultaneous push and pop: count = 2, push and pop each cycle for 10 cycles -> count stays 2 and the output stream stays in order.
